// File: rtl/reg_alu_pipe_if.sv
// Operation/result bundle for reg_alu_pipe: the sequencer drives the master side
// and the datapath core implements the slave side.
interface reg_alu_pipe_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  // Handshake: an operation is taken at a rising edge whenever in_valid=1 (no
  // ready; the core accepts one op per clock). out_valid pulses one cycle after
  // each accepted ALU op (sel=1), marking a fresh alu_out/cout/zero.
  logic              in_valid;
  logic              sel;
  logic              wr;
  logic [2:0]        op;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  d_in;
  logic [WIDTH-1:0]  d_out_a;
  logic [WIDTH-1:0]  d_out_b;
  logic [WIDTH-1:0]  alu_out;
  logic              out_valid;
  logic              cout;
  logic              zero;

  modport master (
    output in_valid, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
    input  d_out_a, d_out_b, alu_out, out_valid, cout, zero
  );

  modport slave (
    input  in_valid, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
    output d_out_a, d_out_b, alu_out, out_valid, cout, zero
  );
endinterface

// File: rtl/reg_alu_pipe.sv
// Execute/writeback core: 2R/1W register file, 8-op ALU with registered carry/zero
// flags, and a one-entry writeback stage that is forwarded to both read ports.
module reg_alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  reg_alu_pipe_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ADC = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  logic [WIDTH-1:0]  r_rf [DEPTH];
  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [WIDTH-1:0]  r_wb_data;
  logic [WIDTH-1:0]  r_alu_out;
  logic              r_cout;
  logic              r_zero;
  logic              r_out_valid;

  logic              w_accept;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH:0]    w_sum;
  logic [WIDTH-1:0]  w_res;
  logic              w_carry;
  logic [WIDTH-1:0]  w_wb_src;

  assign w_accept = bus.in_valid;

  // The pending writeback has not reached the rf yet, so it must win the read.
  assign w_a = (r_wb_valid && (r_wb_addr == bus.rd_addr_a)) ? r_wb_data : r_rf[bus.rd_addr_a];
  assign w_b = (r_wb_valid && (r_wb_addr == bus.rd_addr_b)) ? r_wb_data : r_rf[bus.rd_addr_b];

  // Bit WIDTH of w_sum is the carry-out for every op.
  always_comb begin
    w_sum = '0;
    case (bus.op)
      OP_ADD:  w_sum = {1'b0, w_a} + {1'b0, w_b};
      OP_SUB:  w_sum = {1'b0, w_a} + {1'b0, ~w_b} + ONE;
      OP_ADC:  w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, r_cout};
      OP_AND:  w_sum = {1'b0, w_a & w_b};
      OP_OR:   w_sum = {1'b0, w_a | w_b};
      OP_XOR:  w_sum = {1'b0, w_a ^ w_b};
      OP_SHL:  w_sum = {w_a, 1'b0};
      OP_SHR:  w_sum = {w_a[0], 1'b0, w_a[WIDTH-1:1]};
      default: w_sum = '0;
    endcase
  end

  assign w_res    = w_sum[WIDTH-1:0];
  assign w_carry  = w_sum[WIDTH];
  assign w_wb_src = bus.sel ? w_res : bus.d_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_out   <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_accept && bus.sel) begin
      r_alu_out   <= w_res;
      r_cout      <= w_carry;
      r_zero      <= (w_res == '0);
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else if (w_accept && bus.wr) begin
      r_wb_valid <= 1'b1;
      r_wb_addr  <= bus.wr_addr;
      r_wb_data  <= w_wb_src;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  // Reset wins over a retiring writeback, so a write in flight is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
    end else if (r_wb_valid) begin
      r_rf[r_wb_addr] <= r_wb_data;
    end
  end

  assign bus.d_out_a   = w_a;
  assign bus.d_out_b   = w_b;
  assign bus.alu_out   = r_alu_out;
  assign bus.out_valid = r_out_valid;
  assign bus.cout      = r_cout;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_reg_alu_pipe.sv
// Directed bench for reg_alu_pipe: a 16x8 instance for the main tests and an
// 8-bit, 16-entry instance for the parametric checks.
module tb_reg_alu_pipe;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  reg_alu_pipe_if #(.WIDTH(16), .ADDR_W(3)) bus  ();
  reg_alu_pipe_if #(.WIDTH(8),  .ADDR_W(4)) bus8 ();

  reg_alu_pipe #(.WIDTH(16), .ADDR_W(3)) u_dut  (.clk(clk), .reset(reset), .bus(bus));
  reg_alu_pipe #(.WIDTH(8),  .ADDR_W(4)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation on the 16-bit instance and advance past its edge.
  task automatic drive(input logic v, input logic s, input logic w, input logic [2:0] o,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] wa,
                       input logic [15:0] d);
    bus.in_valid = v; bus.sel = s; bus.wr = w; bus.op = o;
    bus.rd_addr_a = ra; bus.rd_addr_b = rb; bus.wr_addr = wa; bus.d_in = d;
    @(posedge clk); #1;
  endtask

  // Change only the read addresses (no edge) and let the read mux settle.
  task automatic peek(input logic [2:0] ra, input logic [2:0] rb);
    bus.in_valid = 1'b0; bus.wr = 1'b0;
    bus.rd_addr_a = ra; bus.rd_addr_b = rb;
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, 1, 3'd0, 3'd0, 3'd0, 3'd1, 16'h1111);
    drive(1, 0, 1, 3'd0, 3'd1, 3'd3, 3'd3, 16'h3333);
    checks++; if (bus.d_out_a !== 16'h1111) begin failures++; $display("FAIL pre_reset_r1 got=%h exp=1111", bus.d_out_a); end
    checks++; if (bus.d_out_b !== 16'h3333) begin failures++; $display("FAIL pre_reset_r3_fwd got=%h exp=3333", bus.d_out_b); end
    reset = 1'b1;
    drive(0, 0, 0, 3'd0, 3'd1, 3'd3, 3'd0, 16'h0);
    drive(0, 0, 0, 3'd0, 3'd1, 3'd3, 3'd0, 16'h0);
    reset = 1'b0;
    peek(3'd1, 3'd3);
    checks++; if (bus.d_out_a !== 16'h0) begin failures++; $display("FAIL reset_r1 got=%h exp=0000", bus.d_out_a); end
    checks++; if (bus.d_out_b !== 16'h0) begin failures++; $display("FAIL reset_r3 got=%h exp=0000", bus.d_out_b); end
    checks++; if ({bus.cout, bus.zero, bus.out_valid} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {bus.cout, bus.zero, bus.out_valid}); end
    checks++; if (bus.alu_out !== 16'h0) begin failures++; $display("FAIL reset_alu_out got=%h exp=0000", bus.alu_out); end
    drive(0, 0, 0, 3'd0, 3'd3, 3'd1, 3'd0, 16'h0);
    checks++; if (bus.d_out_a !== 16'h0) begin failures++; $display("FAIL reset_r3_lost got=%h exp=0000", bus.d_out_a); end
  endtask

  task automatic test_load_forward;
    drive(1, 0, 1, 3'd0, 3'd0, 3'd0, 3'd3, 16'hCDEF);
    drive(1, 0, 1, 3'd0, 3'd0, 3'd0, 3'd7, 16'h3210);
    peek(3'd3, 3'd7);
    checks++; if (bus.d_out_a !== 16'hCDEF) begin failures++; $display("FAIL load_r3_rf got=%h exp=cdef", bus.d_out_a); end
    checks++; if (bus.d_out_b !== 16'h3210) begin failures++; $display("FAIL load_r7_fwd got=%h exp=3210", bus.d_out_b); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL load_out_valid got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_add_sub;
    drive(1, 1, 1, 3'd0, 3'd3, 3'd7, 3'd2, 16'h0);
    checks++; if (bus.alu_out !== 16'hFFFF) begin failures++; $display("FAIL add_res got=%h exp=ffff", bus.alu_out); end
    checks++; if ({bus.cout, bus.zero, bus.out_valid} !== 3'b001) begin failures++; $display("FAIL add_flags got=%b exp=001", {bus.cout, bus.zero, bus.out_valid}); end
    drive(1, 1, 1, 3'd1, 3'd7, 3'd3, 3'd5, 16'h0);
    checks++; if (bus.alu_out !== 16'h6421) begin failures++; $display("FAIL sub_res got=%h exp=6421", bus.alu_out); end
    checks++; if ({bus.cout, bus.zero, bus.out_valid} !== 3'b001) begin failures++; $display("FAIL sub_flags got=%b exp=001", {bus.cout, bus.zero, bus.out_valid}); end
    drive(0, 1, 1, 3'd0, 3'd2, 3'd5, 3'd6, 16'h0);
    checks++; if (bus.d_out_a !== 16'hFFFF) begin failures++; $display("FAIL add_r2 got=%h exp=ffff", bus.d_out_a); end
    checks++; if (bus.d_out_b !== 16'h6421) begin failures++; $display("FAIL sub_r5 got=%h exp=6421", bus.d_out_b); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.alu_out !== 16'h6421) begin failures++; $display("FAIL idle_alu_hold got=%h exp=6421", bus.alu_out); end
  endtask

  task automatic test_adc_chain;
    drive(1, 0, 1, 3'd0, 3'd0, 3'd0, 3'd1, 16'h8000);
    drive(1, 0, 1, 3'd0, 3'd0, 3'd0, 3'd4, 16'h8000);
    drive(1, 1, 0, 3'd0, 3'd1, 3'd4, 3'd0, 16'h0);
    checks++; if (bus.alu_out !== 16'h0000) begin failures++; $display("FAIL adc_add_res got=%h exp=0000", bus.alu_out); end
    checks++; if ({bus.cout, bus.zero, bus.out_valid} !== 3'b111) begin failures++; $display("FAIL adc_add_flags got=%b exp=111", {bus.cout, bus.zero, bus.out_valid}); end
    drive(1, 1, 0, 3'd2, 3'd0, 3'd0, 3'd0, 16'h0);
    checks++; if (bus.alu_out !== 16'h0001) begin failures++; $display("FAIL adc_res got=%h exp=0001", bus.alu_out); end
    checks++; if ({bus.cout, bus.zero, bus.out_valid} !== 3'b001) begin failures++; $display("FAIL adc_flags got=%b exp=001", {bus.cout, bus.zero, bus.out_valid}); end
  endtask

  task automatic test_shift_logic;
    drive(1, 0, 1, 3'd0, 3'd0, 3'd0, 3'd6, 16'h8001);
    drive(1, 1, 0, 3'd6, 3'd6, 3'd0, 3'd0, 16'h0);
    checks++; if ({bus.cout, bus.alu_out} !== {1'b1, 16'h0002}) begin failures++; $display("FAIL shl got=%b/%h exp=1/0002", bus.cout, bus.alu_out); end
    drive(1, 1, 0, 3'd7, 3'd6, 3'd0, 3'd0, 16'h0);
    checks++; if ({bus.cout, bus.zero, bus.alu_out} !== {2'b10, 16'h4000}) begin failures++; $display("FAIL shr got=%b%b/%h exp=10/4000", bus.cout, bus.zero, bus.alu_out); end
    drive(1, 1, 0, 3'd5, 3'd6, 3'd6, 3'd0, 16'h0);
    checks++; if ({bus.cout, bus.zero, bus.alu_out} !== {2'b01, 16'h0000}) begin failures++; $display("FAIL xor_self got=%b%b/%h exp=01/0000", bus.cout, bus.zero, bus.alu_out); end
    drive(1, 1, 0, 3'd4, 3'd6, 3'd3, 3'd6, 16'h0);
    checks++; if (bus.alu_out !== 16'hCDEF) begin failures++; $display("FAIL or_res got=%h exp=cdef", bus.alu_out); end
    drive(1, 1, 0, 3'd3, 3'd6, 3'd3, 3'd6, 16'h0);
    checks++; if (bus.alu_out !== 16'h8001) begin failures++; $display("FAIL and_res got=%h exp=8001", bus.alu_out); end
    peek(3'd6, 3'd6);
    checks++; if (bus.d_out_a !== 16'h8001) begin failures++; $display("FAIL nowrite_r6 got=%h exp=8001", bus.d_out_a); end
  endtask

  task automatic test_nonalu_hold;
    drive(1, 0, 1, 3'd0, 3'd0, 3'd0, 3'd5, 16'h1234);
    checks++; if ({bus.out_valid, bus.alu_out} !== {1'b0, 16'h8001}) begin failures++; $display("FAIL sel0_hold got=%b/%h exp=0/8001", bus.out_valid, bus.alu_out); end
    drive(0, 1, 1, 3'd0, 3'd5, 3'd5, 3'd5, 16'hFFFF);
    checks++; if ({bus.out_valid, bus.alu_out} !== {1'b0, 16'h8001}) begin failures++; $display("FAIL invalid_hold got=%b/%h exp=0/8001", bus.out_valid, bus.alu_out); end
    checks++; if (bus.d_out_a !== 16'h1234) begin failures++; $display("FAIL invalid_r5 got=%h exp=1234", bus.d_out_a); end
  endtask

  task automatic test_back_to_back;
    drive(1, 1, 1, 3'd0, 3'd5, 3'd5, 3'd5, 16'h0);
    checks++; if (bus.alu_out !== 16'h2468) begin failures++; $display("FAIL b2b_first got=%h exp=2468", bus.alu_out); end
    drive(1, 1, 1, 3'd0, 3'd5, 3'd5, 3'd5, 16'h0);
    checks++; if (bus.alu_out !== 16'h48D0) begin failures++; $display("FAIL b2b_second got=%h exp=48d0", bus.alu_out); end
    drive(0, 0, 0, 3'd0, 3'd5, 3'd2, 3'd0, 16'h0);
    checks++; if ({bus.d_out_a, bus.d_out_b} !== {16'h48D0, 16'hFFFF}) begin failures++; $display("FAIL b2b_regs got=%h/%h exp=48d0/ffff", bus.d_out_a, bus.d_out_b); end
  endtask

  task automatic test_param;
    bus8.in_valid = 1; bus8.sel = 0; bus8.wr = 1; bus8.op = 3'd0;
    bus8.rd_addr_a = 4'd0; bus8.rd_addr_b = 4'd0; bus8.wr_addr = 4'd15; bus8.d_in = 8'hFF;
    @(posedge clk); #1;
    bus8.sel = 1; bus8.rd_addr_a = 4'd15; bus8.rd_addr_b = 4'd15; bus8.wr_addr = 4'd14;
    @(posedge clk); #1;
    checks++; if ({bus8.cout, bus8.zero, bus8.out_valid, bus8.alu_out} !== {3'b101, 8'hFE}) begin failures++; $display("FAIL p8_add got=%b%b%b/%h exp=101/fe", bus8.cout, bus8.zero, bus8.out_valid, bus8.alu_out); end
    bus8.in_valid = 0; bus8.op = 3'd5; bus8.rd_addr_a = 4'd14; bus8.wr_addr = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus8.cout, bus8.out_valid, bus8.alu_out} !== {2'b10, 8'hFE}) begin failures++; $display("FAIL p8_idle_hold got=%b%b/%h exp=10/fe", bus8.cout, bus8.out_valid, bus8.alu_out); end
    checks++; if ({bus8.d_out_a, bus8.d_out_b} !== {8'hFE, 8'hFF}) begin failures++; $display("FAIL p8_regs got=%h/%h exp=fe/ff", bus8.d_out_a, bus8.d_out_b); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.in_valid = 0; bus.sel = 0; bus.wr = 0; bus.op = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.wr_addr = '0; bus.d_in = '0;
    bus8.in_valid = 0; bus8.sel = 0; bus8.wr = 0; bus8.op = '0;
    bus8.rd_addr_a = '0; bus8.rd_addr_b = '0; bus8.wr_addr = '0; bus8.d_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_load_forward();
    test_add_sub();
    test_adc_chain();
    test_shift_logic();
    test_nonalu_hold();
    test_back_to_back();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_alu_pipe.md
# reg_alu_pipe

Parametrised successor to the 8×16 register-file/ALU datapath. It pairs a DEPTH×WIDTH two-read/one-write register file with an 8-operation ALU. Results and d_in writes pass through a one-entry writeback stage, with read-after-write forwarding. Registered carry and zero flags support multi-word add-with-carry chains. The block is the execute/writeback core the sequencer drives one operation per clock.

## Interface
Parameters:
- WIDTH, 16, data width of registers, d_in, ALU operands and results
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk
- in_valid  in  1  operation present this cycle; when 0, no new operation is accepted
- sel  in  1  1 = write source is the ALU result; 0 = write source is d_in
- wr  in  1  1 = write the selected source to wr_addr
- op  in  3  ALU opcode, used only when sel=1
- rd_addr_a, rd_addr_b  in  ADDR_W  read addresses, also the ALU operands A and B
- wr_addr  in  ADDR_W  write destination
- d_in  in  WIDTH  external write data
- d_out_a, d_out_b  out  WIDTH  combinational forwarded read data
- alu_out  out  WIDTH  registered result of the last accepted ALU op
- out_valid  out  1  one-cycle pulse: alu_out was updated at the previous edge
- cout  out  1  registered carry flag
- zero  out  1  registered zero flag: 1 when the last ALU result was 0

## Operation
- Accept: an operation is accepted at a rising edge when in_valid=1 and reset=0.
- Operands: A = d_out_a and B = d_out_b, both forwarded (see below).
- ALU ops, all results truncated to WIDTH:
  - 000 ADD: {cout,res} = A+B
  - 001 SUB: {cout,res} = A+~B+1; cout=1 means no borrow
  - 010 ADC: {cout,res} = A+B+cout, using the registered cout
  - 011 AND, 100 OR, 101 XOR: cout←0
  - 110 SHL by 1: cout←A[WIDTH-1]
  - 111 SHR logical by 1: cout←A[0]
- ALU-op flag update: accepting an op with sel=1 loads alu_out←res, cout and zero←(res==0), and out_valid←1 at the same edge, whether or not wr=1.
- Non-ALU accept: with sel=0, alu_out, cout and zero hold and out_valid←0.
- Writeback stage (wb_valid, wb_addr, wb_data): at an accept edge with wr=1, it loads wb_addr←wr_addr and wb_data←(sel ? res : d_in), and sets wb_valid←1. Otherwise wb_valid←0.
- Register-file write: rf[wb_addr]←wb_data at every edge where wb_valid=1. This can coincide with a new writeback capture at the same edge.
- Forwarding: d_out_x = (wb_valid && wb_addr==rd_addr_x) ? wb_data : rf[rd_addr_x]. Applies independently to port A and port B.
- Same address on both reads, or a read address equal to wr_addr: legal. The read returns the pre-edge value; the new value is visible from the next cycle.
- in_valid=0: only the pending writeback retires, and out_valid←0.

## Timing
- Reset values:
  - all rf entries and alu_out are 0
  - cout, zero=0 (zero is not 1 at reset)
  - out_valid=0
  - wb_valid=0
  - d_out_a/d_out_b therefore read 0
- Reset during a pending write discards that write; rf stays all-zero.
- Write latency:
  - accept edge N, rf updated at edge N+1
  - the value is visible on d_out via forwarding from just after edge N
  - full throughput of one op per cycle, no stalls
- Flag latency:
  - cout, zero and alu_out are valid just after accept edge N
  - out_valid is high during cycle N→N+1 only
  - back-to-back ADC chains use the previous op's carry with no bubble
- Read ports: combinational from rf/wb state; no dependency on current-cycle inputs other than the read addresses.

## Test plan
- Reset: hold reset 2 cycles after writes to r1 and r3.
  - Expect all reads 0, cout=0, zero=0, out_valid=0.
  - Assert reset the cycle after an accepted write: the write is lost.
- Load and forward: write 0xCDEF→r3, then 0x3210→r7 on consecutive cycles, with rd_a=3, rd_b=7 in the cycle after the second write.
  - Expect d_out_a=0xCDEF (from rf) and d_out_b=0x3210 (forwarded).
- ADD/SUB: sel=1, wr=1, ADD r3+r7→r2.
  - Expect alu_out=0xFFFF, cout=0, zero=0, out_valid pulse, r2=0xFFFF.
  - SUB r7−r3: expect 0x6421, cout=0.
- ADC chain:
  - Write 0x8000 to r1 and r4.
  - ADD r1+r4: expect 0x0000, cout=1, zero=1.
  - Immediately ADC r0+r0: expect 0x0001, cout=0, zero=0.
- Shifts/logic on 0x8001:
  - SHL gives 0x0002, cout=1.
  - SHR gives 0x4000, cout=1.
  - XOR with itself gives 0, cout=0, zero=1.
  - sel=1, wr=0 updates flags but no register.
- Parametric: instantiate with WIDTH=8, ADDR_W=4; write r15=0xFF, ADD r15+r15.
  - Expect 0xFE, cout=1.
  - in_valid=0 cycles leave all state except a pending writeback unchanged.
